// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types, constants and helpers for the LED mode controller
package led_pkg;

    localparam int LED_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SHIFT = 2'd2,
        BLINK = 2'd3
    } mode_t;

    localparam logic [LED_W_DEFAULT-1:0] ENTRY_IDLE  = 4'b0000;
    localparam logic [LED_W_DEFAULT-1:0] ENTRY_COUNT = 4'b0000;
    localparam logic [LED_W_DEFAULT-1:0] ENTRY_SHIFT = 4'b0001;
    localparam logic [LED_W_DEFAULT-1:0] ENTRY_BLINK = 4'b0000;

    // Pattern loaded into the LED register when a mode is entered
    function automatic logic [LED_W_DEFAULT-1:0] entry_led(input mode_t m);
        case (m)
            COUNT:   entry_led = ENTRY_COUNT;
            SHIFT:   entry_led = ENTRY_SHIFT;
            BLINK:   entry_led = ENTRY_BLINK;
            default: entry_led = ENTRY_IDLE;
        endcase
    endfunction

    // Mode sequence on each advance press: IDLE -> COUNT -> SHIFT -> BLINK -> IDLE
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            IDLE:    next_mode = COUNT;
            COUNT:   next_mode = SHIFT;
            SHIFT:   next_mode = BLINK;
            default: next_mode = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, debouncer and press-edge pulse
module btn_debounce #(
    parameter int DEB_CYCLES = 100000
) (
    input  logic clk,
    input  logic nrst,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_press;
    logic          r_armed;
    logic [1:0]    r_vld;
    logic [CW-1:0] r_cnt;

    // Two-flop synchroniser for the asynchronous raw button
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Arm press detection only once the button has been seen released after
    // reset, so a button held through reset cannot fire a press.
    // r_vld marks when r_sync2 carries a real sample instead of its reset value.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_vld   <= {r_vld[0], 1'b1};
            r_armed <= r_armed | (r_vld[1] & r_sync2);
        end
    end

    // Accept a new level after DEB_CYCLES consecutive differing samples; pulse on 1->0
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_cnt    <= '0;
            r_stable <= 1'b1;
            r_press  <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_press  <= ~r_sync2 & r_armed;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign stable = r_stable;
    assign press  = r_press;

endmodule

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - button-driven LED mode sequencer with prescaled update tick
module led_mode_ctrl
    import led_pkg::*;
#(
    parameter int TICK_DIV   = 10000000,
    parameter int DEB_CYCLES = 100000,
    parameter int LED_W      = LED_W_DEFAULT
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             but1,
    input  logic             but2,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic             running,
    output logic             tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic             w_press1;
    logic             w_press2;
    logic             w_unused_stable1;
    logic             w_unused_stable2;

    mode_t            r_mode;
    mode_t            w_mode_nxt;
    logic [LED_W-1:0] r_led;
    logic [LED_W-1:0] w_led_nxt;
    logic [PW-1:0]    r_presc;
    logic [PW-1:0]    w_presc_nxt;
    logic             r_running;
    logic             w_running_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             w_advance;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb1 (
        .clk    (clk),
        .nrst   (nrst),
        .raw    (but1),
        .stable (w_unused_stable1),
        .press  (w_press1)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb2 (
        .clk    (clk),
        .nrst   (nrst),
        .raw    (but2),
        .stable (w_unused_stable2),
        .press  (w_press2)
    );

    // State register: mode, LED pattern, prescaler, run flag and tick pulse
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_mode    <= IDLE;
            r_led     <= '0;
            r_presc   <= '0;
            r_running <= 1'b1;
            r_tick    <= 1'b0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_led     <= w_led_nxt;
            r_presc   <= w_presc_nxt;
            r_running <= w_running_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    // Next state: a mode press overrides both pause/resume and any tick due this cycle
    always_comb begin
        w_mode_nxt    = r_mode;
        w_led_nxt     = r_led;
        w_presc_nxt   = r_presc;
        w_running_nxt = r_running;
        w_tick_nxt    = 1'b0;
        w_advance     = r_running && (r_mode != IDLE);

        if (w_press1) begin
            w_mode_nxt    = next_mode(r_mode);
            w_led_nxt     = LED_W'(entry_led(w_mode_nxt));
            w_presc_nxt   = '0;
            w_running_nxt = 1'b1;
        end else begin
            if (w_press2 && (r_mode != IDLE)) begin
                w_running_nxt = ~r_running;
            end
            if (w_advance) begin
                if (r_presc == PRESC_LAST) begin
                    w_presc_nxt = '0;
                    w_tick_nxt  = 1'b1;
                    case (r_mode)
                        COUNT:   w_led_nxt = r_led + LED_W'(1);
                        SHIFT:   w_led_nxt = {r_led[LED_W-2:0], r_led[LED_W-1]};
                        BLINK:   w_led_nxt = ~r_led;
                        default: w_led_nxt = r_led;
                    endcase
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end
        end
    end

    assign led     = r_led;
    assign mode    = r_mode;
    assign running = r_running;
    assign tick    = r_tick;

endmodule
